// File: rtl/circle_frame_sched_pkg.sv
// Shared types and constants for the circle frame scheduler and its clear sweeper.
package circle_frame_sched_pkg;

  localparam int unsigned DEF_X_MAX = 160;
  localparam int unsigned DEF_Y_MAX = 120;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/circle_frame_sched_clear_sweeper.sv
// Raster sweep over the whole screen, x fastest; steps one pixel per cycle while start is high.
module clear_sweeper
  import circle_frame_sched_pkg::*;
#(
  parameter int unsigned X_MAX = DEF_X_MAX,
  parameter int unsigned Y_MAX = DEF_Y_MAX
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  output logic [cnt_w(X_MAX)-1:0]   x,
  output logic [cnt_w(Y_MAX)-1:0]   y,
  output logic                      last
);

  localparam int unsigned XW = cnt_w(X_MAX);
  localparam int unsigned YW = cnt_w(Y_MAX);

  // x/y name the pixel to be emitted next; last marks the cycle after the final pixel went out.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      last <= 1'b0;
    end else if (start) begin
      if (x == XW'(X_MAX - 1)) begin
        x <= '0;
        if (y == YW'(Y_MAX - 1)) begin
          y    <= '0;
          last <= 1'b1;
        end else begin
          y    <= y + YW'(1);
          last <= 1'b0;
        end
      end else begin
        x    <= x + XW'(1);
        last <= 1'b0;
      end
    end else begin
      last <= 1'b0;
    end
  end

endmodule

// File: rtl/circle_frame_sched.sv
// Frame scheduler for the circle demo: owns the pixel port and sequences clear, draw and hold.
// Build option SCHED_CLEAR_EN: blank the screen before each circle; without it circles accumulate.
module circle_frame_sched
  import circle_frame_sched_pkg::*;
#(
  parameter int unsigned X_MAX       = DEF_X_MAX,
  parameter int unsigned Y_MAX       = DEF_Y_MAX,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       run,
  output logic       draw_start,
  input  logic       draw_done,
  input  logic       pix_valid,
  input  logic [7:0] pix_x,
  input  logic [6:0] pix_y,
  input  logic [2:0] pix_colour,
  output logic       new_params,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  state_e          st, st_d;
  logic [HW-1:0]   hold_cnt, hold_cnt_d;
  logic            draw_start_d, new_params_d, vga_plot_d, busy_d;
  logic [7:0]      vga_x_d;
  logic [6:0]      vga_y_d;
  logic [2:0]      vga_colour_d;

`ifdef SCHED_CLEAR_EN
  localparam state_e FRAME_START = CLEAR;

  logic                     sweep_step;
  logic [cnt_w(X_MAX)-1:0]  sw_x;
  logic [cnt_w(Y_MAX)-1:0]  sw_y;
  logic                     sw_last;

  clear_sweeper #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_sweeper (
    .clock  (clock),
    .resetn (resetn),
    .start  (sweep_step),
    .x      (sw_x),
    .y      (sw_y),
    .last   (sw_last)
  );
`else
  localparam state_e FRAME_START = DRAW;
`endif

  // Next state plus next output values; outputs are registered from these.
  always_comb begin
    st_d         = st;
    hold_cnt_d   = '0;
    draw_start_d = 1'b0;
    new_params_d = 1'b0;
    vga_plot_d   = 1'b0;
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = COLOUR_BLACK;
    busy_d       = 1'b0;
`ifdef SCHED_CLEAR_EN
    sweep_step   = 1'b0;
`endif

    case (st)
      IDLE: begin
        if (run) st_d = FRAME_START;
      end
`ifdef SCHED_CLEAR_EN
      CLEAR: begin
        if (sw_last) st_d = DRAW;
      end
`endif
      DRAW: begin
        // Datapath pixel from this cycle lands on the port next cycle, even alongside draw_done.
        vga_x_d      = pix_x;
        vga_y_d      = pix_y;
        vga_colour_d = pix_colour;
        vga_plot_d   = pix_valid && (32'(pix_x) < X_MAX) && (32'(pix_y) < Y_MAX);
        if (draw_done) st_d = HOLD;
      end
      HOLD: begin
        hold_cnt_d   = hold_cnt + HW'(1);
        new_params_d = (hold_cnt == HW'(HOLD_CYCLES - 1));
        if (hold_cnt == HW'(HOLD_CYCLES)) begin
          hold_cnt_d = '0;
          st_d       = run ? FRAME_START : IDLE;
        end
      end
      default: st_d = IDLE;
    endcase

`ifdef SCHED_CLEAR_EN
    // The clear pixel goes out together with the state it belongs to.
    if (st_d == CLEAR) begin
      sweep_step   = 1'b1;
      vga_x_d      = 8'(sw_x);
      vga_y_d      = 7'(sw_y);
      vga_colour_d = COLOUR_BLACK;
      vga_plot_d   = 1'b1;
    end
`endif

    draw_start_d = (st_d == DRAW) && (st != DRAW);
    busy_d       = (st_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st         <= IDLE;
      hold_cnt   <= '0;
      draw_start <= 1'b0;
      new_params <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      busy       <= 1'b0;
    end else begin
      st         <= st_d;
      hold_cnt   <= hold_cnt_d;
      draw_start <= draw_start_d;
      new_params <= new_params_d;
      vga_plot   <= vga_plot_d;
      vga_x      <= vga_x_d;
      vga_y      <= vga_y_d;
      vga_colour <= vga_colour_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_circle_frame_sched.sv
// Scoreboard bench: frame-level expectations queued by the driver, compared per cycle by a monitor.
module tb_circle_frame_sched;

  localparam int unsigned XM = 4;
  localparam int unsigned YM = 3;
  localparam int unsigned HC = 4;
`ifdef SCHED_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn, run, draw_start, draw_done, pix_valid, new_params, vga_plot, busy;
  logic [7:0] pix_x, vga_x;
  logic [6:0] pix_y, vga_y;
  logic [2:0] pix_colour, vga_colour;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         ds, np, plot, busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         ph;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  circle_frame_sched #(
    .X_MAX       (XM),
    .Y_MAX       (YM),
    .HOLD_CYCLES (HC)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .run        (run),
    .draw_start (draw_start),
    .draw_done  (draw_done),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .new_params (new_params),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Monitor: one expected output record per cycle, checked away from the active edge.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (draw_start !== mon_e.ds || new_params !== mon_e.np || vga_plot !== mon_e.plot ||
          busy !== mon_e.busy ||
          (mon_e.plot && (vga_x !== mon_e.x || vga_y !== mon_e.y || vga_colour !== mon_e.c))) begin
        n_bad++;
        $display("FAIL out_phase%0d @%0t: got ds=%b np=%b plot=%b busy=%b pix=(%0d,%0d,%0d) want ds=%b np=%b plot=%b busy=%b pix=(%0d,%0d,%0d)",
                 mon_e.ph, $time, draw_start, new_params, vga_plot, busy, vga_x, vga_y, vga_colour,
                 mon_e.ds, mon_e.np, mon_e.plot, mon_e.busy, mon_e.x, mon_e.y, mon_e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, want finish before 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input bit ds, input bit np, input bit plot, input bit bsy,
                      input logic [7:0] x, input logic [6:0] y, input logic [2:0] c, input int ph);
    exp_t e;
    e.ds = ds; e.np = np; e.plot = plot; e.busy = bsy;
    e.x = x; e.y = y; e.c = c; e.ph = ph;
    exp_q.push_back(e);
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // Random datapath noise; the scheduler must ignore it outside DRAW.
  task automatic junk();
    pix_valid  = 1'($urandom);
    pix_x      = 8'($urandom);
    pix_y      = 7'($urandom);
    pix_colour = 3'($urandom);
    draw_done  = 1'($urandom);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({draw_start, new_params, vga_plot, busy, vga_x, vga_y, vga_colour} !== '0) begin
      n_bad++;
      $display("FAIL %s: got outputs %h, want all zero", name,
               {draw_start, new_params, vga_plot, busy, vga_x, vga_y, vga_colour});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next(); junk(); run = 1'b0;
      push(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Decision cycle: run raised while idle; the frame body starts next cycle.
  task automatic launch();
    next(); junk(); run = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One frame: optional clear sweep, n_draw datapath cycles, drain cycle, hold.
  task automatic frame_body(input int n_draw, input bit stop, input bit keep_run,
                            input int abort_d, input bit directed);
    bit pp, v;
    logic [7:0] px, x;
    logic [6:0] py, y;
    logic [2:0] pc, c;
    if (CLEAR_EN) begin
      for (int p = 0; p < int'(XM * YM); p++) begin
        next(); junk(); run = stop ? 1'b0 : 1'($urandom);
        push(0, 0, 1, 1, 8'(p % XM), 7'(p / XM), 3'b000, 1);
      end
    end
    pp = 1'b0; px = '0; py = '0; pc = '0;
    for (int d = 0; d < n_draw; d++) begin
      next();
      if (d == abort_d) begin
        resetn = 1'b0; run = 1'b0;
        #1 check_zero("async_reset_in_draw");
        push(0, 0, 0, 0, 0, 0, 0, 2);
        return;
      end
      push(d == 0, 0, pp, 1, px, py, pc, 2);
      x = 8'($urandom_range(0, 5)); y = 7'($urandom_range(0, 4));
      c = 3'($urandom); v = 1'($urandom);
      if (directed && d == 0) begin x = 8'd2; y = 7'd1; c = 3'b101; v = 1'b1; end
      if (directed && d == 1) begin x = 8'd4; y = 7'd1; v = 1'b1; end
      if (directed && d == 2) begin x = 8'd1; y = 7'd3; v = 1'b1; end
      if (directed && d == n_draw - 1) begin x = 8'd1; y = 7'd1; v = 1'b1; end
      pix_valid = v; pix_x = x; pix_y = y; pix_colour = c;
      draw_done = (d == n_draw - 1);
      run = stop ? 1'b0 : 1'($urandom);
      pp = v && (x < XM) && (y < YM);
      px = x; py = y; pc = c;
    end
    next(); junk(); run = stop ? 1'b0 : 1'($urandom);
    push(0, 0, pp, 1, px, py, pc, 3);
    for (int h = 1; h <= int'(HC); h++) begin
      next(); junk();
      run = (h == int'(HC)) ? keep_run : (stop ? 1'b0 : 1'($urandom));
      push(0, h == int'(HC), 0, 1, 0, 0, 0, 3);
    end
  endtask

  initial begin
    bit keep;
    resetn = 1'b1; run = 1'b0; draw_done = 1'b0; pix_valid = 1'b0;
    pix_x = '0; pix_y = '0; pix_colour = '0;
    #1 resetn = 1'b0;
    #1 check_zero("reset_state");
    next(); next();
    resetn = 1'b1; junk(); run = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Directed frame with passthrough/handover pixels, continuing into a frame stopped early.
    launch();
    frame_body(6, 1'b0, 1'b1, -1, 1'b1);
    frame_body(int'($urandom_range(2, 6)), 1'b1, 1'b0, -1, 1'b0);
    idle(4);

    // Reset while drawing, then a stray draw_done while idle.
    launch();
    frame_body(6, 1'b0, 1'b1, 3, 1'b0);
    repeat (2) begin
      next(); junk(); run = 1'b0;
      push(0, 0, 0, 0, 0, 0, 0, 0);
    end
    next(); resetn = 1'b1; junk(); draw_done = 1'b1; run = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random frame sequences, some back to back.
    for (int f = 0; f < 6; f++) begin
      launch();
      for (int k = 0; k < 3; k++) begin
        keep = (k < 2) && 1'($urandom);
        frame_body(int'($urandom_range(1, 7)), 1'b0, keep, -1, 1'b0);
        if (!keep) break;
      end
      idle(int'($urandom_range(1, 3)));
    end

    next();
    @(negedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
